// File: rtl/mem_readback_controller.sv
// Frame-buffer read-back engine: sequential word reads from memory,
// buffered and serialised into bytes for the host transmitter.
module mem_readback_controller #(
  parameter int ADDRESS_WIDTH = 25,
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_address,
  input  logic [15:0]              word_count,
  input  logic                     color_format,
  input  logic                     abort,
  output logic [ADDRESS_WIDTH-1:0] address_mem,
  output logic                     rd_mem,
  input  logic                     fifo_full_mem,
  input  logic [DATA_WIDTH-1:0]    data_in_mem,
  input  logic                     data_in_ready_mem,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_nxt;

  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [15:0]              req_left;
  logic [16:0]              bytes_left;
  logic                     fmt_q;
  logic [CW-1:0]            outstanding;
  logic [CW-1:0]            fifo_count;
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [DATA_WIDTH-1:0]    fifo_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    head;
  logic                     lo_pend;
  logic [7:0]               lo_byte;
  logic [7:0]               tx_data_q;
  logic                     tx_valid_q;
  logic                     done_q;

  logic          start_ok;
  logic          issue;
  logic          ret;
  logic          push;
  logic          pop;
  logic          tx_fire;
  logic          last_byte;
  logic [CW:0]   inflight;

  // Credit covers words in flight, buffered, and held by the serialiser
  assign inflight = {1'b0, outstanding}
                  + {1'b0, fifo_count}
                  + {{CW{1'b0}}, tx_valid_q};

  assign start_ok  = (state == IDLE) && start && !abort
                   && (outstanding == '0);
  assign issue     = (state == RUN) && !abort
                   && (req_left != 16'd0)
                   && !fifo_full_mem
                   && (inflight < (CW+1)'(FIFO_DEPTH));
  assign ret       = data_in_ready_mem && (outstanding != '0);
  assign push      = ret && (state == RUN);
  assign tx_fire   = tx_valid_q && tx_ready;
  assign pop       = (state == RUN) && (fifo_count != '0)
                   && (!tx_valid_q || (tx_ready && !lo_pend));
  assign last_byte = tx_fire && (bytes_left == 17'd1);
  assign head      = fifo_mem[rd_ptr];

  assign rd_mem      = issue;
  assign address_mem = addr_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign busy        = (state == RUN);
  assign done        = done_q;

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_ok && (word_count != 16'd0))
          state_nxt = RUN;
      end
      RUN: begin
        if (abort)          state_nxt = IDLE;
        else if (last_byte) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      addr_q      <= '0;
      req_left    <= '0;
      bytes_left  <= '0;
      fmt_q       <= 1'b0;
      outstanding <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      outstanding <= outstanding + CW'(issue) - CW'(ret);
      if (start_ok) begin
        addr_q     <= start_address;
        req_left   <= word_count;
        fmt_q      <= color_format;
        bytes_left <= color_format ? {word_count, 1'b0}
                                   : {1'b0, word_count};
        done_q     <= (word_count == 16'd0);
      end else if (issue) begin
        addr_q   <= addr_q + 1'b1;
        req_left <= req_left - 16'd1;
      end
      if (tx_fire && (state == RUN) && !abort) begin
        bytes_left <= bytes_left - 17'd1;
        if (last_byte) done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= data_in_mem;
  end

  always_ff @(posedge clk_sys) begin
    if (reset || abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Two-byte words present the high byte first and park the low byte
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      lo_pend    <= 1'b0;
      lo_byte    <= '0;
    end else if (abort) begin
      tx_valid_q <= 1'b0;
      lo_pend    <= 1'b0;
    end else if (pop) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= fmt_q ? head[15:8] : head[7:0];
      lo_pend    <= fmt_q;
      lo_byte    <= head[7:0];
    end else if (tx_fire) begin
      if (lo_pend) begin
        tx_data_q <= lo_byte;
        lo_pend   <= 1'b0;
      end else begin
        tx_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_readback_controller.sv
// Scoreboard bench for mem_readback_controller with a
// fixed-latency memory model and a negedge monitor.
module tb_mem_readback_controller;

  localparam int AW    = 25;
  localparam int DEPTH = 4;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_address;
  logic [15:0]   word_count;
  logic          color_format;
  logic          abort;
  logic [AW-1:0] address_mem;
  logic          rd_mem;
  logic          fifo_full_mem;
  logic [15:0]   data_in_mem;
  logic          data_in_ready_mem;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done;

  always #5 clk_sys = ~clk_sys;

  mem_readback_controller #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(16),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .start(start),
    .start_address(start_address),
    .word_count(word_count),
    .color_format(color_format),
    .abort(abort),
    .address_mem(address_mem),
    .rd_mem(rd_mem),
    .fifo_full_mem(fifo_full_mem),
    .data_in_mem(data_in_mem),
    .data_in_ready_mem(data_in_ready_mem),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .done(done)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            lat      = 2;
  int            rd_cnt   = 0;
  int            done_cnt = 0;
  logic [AW-1:0] addr_q [$];
  logic [7:0]    byte_q [$];
  ret_t          pend   [$];
  logic          hold_prev = 1'b0;
  logic [7:0]    hold_data = '0;

  function automatic logic [15:0] mem_word(logic [AW-1:0] a);
    if (a == 25'h200) return 16'hA1B2;
    if (a == 25'h201) return 16'hC3D4;
    return {~a[7:0], a[7:0] ^ 8'h5A};
  endfunction

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Memory model and output monitor
  initial begin
    data_in_ready_mem = 1'b0;
    data_in_mem       = '0;
    forever begin
      ret_t r;
      @(negedge clk_sys);
      cyc++;
      data_in_ready_mem = 1'b0;
      data_in_mem       = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        data_in_ready_mem = 1'b1;
        data_in_mem       = r.data;
      end
      if (rd_mem) begin
        rd_cnt++;
        pend.push_back('{cyc + lat, mem_word(address_mem)});
        if (addr_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", address_mem, addr_q.pop_front());
      end
      if (fifo_full_mem) chk("rd_while_full", rd_mem, 0);
      if (hold_prev) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, hold_data);
      end
      hold_prev = tx_valid && !tx_ready && !abort;
      hold_data = tx_data;
      if (tx_valid && tx_ready) begin
        if (byte_q.size() == 0) chk("tx_unexpected", 1, 0);
        else chk("tx_byte", tx_data, byte_q.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_start(logic [AW-1:0] a, logic [15:0] n,
                          logic f);
    @(posedge clk_sys);
    #1;
    start         = 1'b1;
    start_address = a;
    word_count    = n;
    color_format  = f;
    @(posedge clk_sys);
    #1;
    start = 1'b0;
  endtask

  task automatic expect_run(logic [AW-1:0] a, int n, logic f);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] ai;
      logic [15:0]   w;
      ai = a + AW'(i);
      w  = mem_word(ai);
      addr_q.push_back(ai);
      if (f) byte_q.push_back(w[15:8]);
      byte_q.push_back(w[7:0]);
    end
  endtask

  task automatic wait_done(string name, int maxc);
    int k = 0;
    while (done !== 1'b1 && k < maxc) begin
      @(posedge clk_sys);
      #1;
      k++;
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_busy_low"}, busy, 0);
  endtask

  task automatic drained(string name, int exp_done);
    idle(2);
    chk({name, "_done_cnt"}, done_cnt, exp_done);
    chk({name, "_drain"}, addr_q.size() + byte_q.size(), 0);
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    start_address = '0;
    word_count    = '0;
    color_format  = 1'b0;
    abort         = 1'b0;
    fifo_full_mem = 1'b0;
    tx_ready      = 1'b1;
    idle(3);
    chk("rst_rd_mem", rd_mem, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", address_mem, 0);
    chk("rst_tx_data", tx_data, 0);
    reset = 1'b0;
    idle(2);

    expect_run(25'h100, 3, 1'b0);
    do_start(25'h100, 16'd3, 1'b0);
    chk("t1_busy", busy, 1);
    wait_done("t1", 100);
    drained("t1", 1);

    expect_run(25'h200, 2, 1'b1);
    do_start(25'h200, 16'd2, 1'b1);
    wait_done("t2", 100);
    drained("t2", 2);

    tx_ready = 1'b0;
    rd_cnt   = 0;
    expect_run(25'h400, 10, 1'b0);
    do_start(25'h400, 16'd10, 1'b0);
    idle(5);
    do_start(25'h999, 16'd5, 1'b1);
    idle(14);
    chk("t3_rd_le_depth", rd_cnt <= DEPTH, 1);
    chk("t3_rd_some", rd_cnt > 0, 1);
    chk("t3_busy", busy, 1);
    tx_ready = 1'b1;
    wait_done("t3", 300);
    drained("t3", 3);

    expect_run(25'h1FFFFFF, 2, 1'b0);
    do_start(25'h1FFFFFF, 16'd2, 1'b0);
    wait_done("t4", 100);
    drained("t4", 4);

    lat = 3;
    expect_run(25'h500, 8, 1'b0);
    do_start(25'h500, 16'd8, 1'b0);
    idle(2);
    fifo_full_mem = 1'b1;
    rd_cnt        = 0;
    idle(5);
    fifo_full_mem = 1'b0;
    chk("t5_no_rd_full", rd_cnt, 0);
    wait_done("t5", 200);
    drained("t5", 5);

    do_start(25'h800, 16'd0, 1'b0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    idle(1);
    chk("z_done_pulse", done, 0);
    drained("z", 6);

    lat = 8;
    addr_q.push_back(25'h600);
    addr_q.push_back(25'h601);
    do_start(25'h600, 16'd2, 1'b0);
    idle(3);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    do_start(25'h700, 16'd1, 1'b0);
    chk("ab_ign_busy", busy, 0);
    chk("ab_ign_done", done, 0);
    idle(12);
    lat = 2;
    expect_run(25'h300, 1, 1'b0);
    do_start(25'h300, 16'd1, 1'b0);
    wait_done("ab", 100);
    drained("ab", 7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
